// File: rtl/blt_pkg.sv
// Shared definitions for the SC1 blitter bus responder: state encoding and nibble masks.
package blt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_BA = 3'd1,
    GRANT   = 3'd2,
    RD      = 3'd3,
    WR      = 3'd4,
    RMW_RD  = 3'd5,
    RMW_WR  = 3'd6,
    ACK     = 3'd7
  } blt_state_e;

  localparam logic [7:0] NIB_UPPER_MASK = 8'hF0;
  localparam logic [7:0] NIB_LOWER_MASK = 8'h0F;
  localparam logic [1:0] NIB_EN_ALL     = 2'b11;

endpackage

// File: rtl/blt_nib_merge.sv
// Combinational nibble merge: enabled nibbles from new_byte, the rest from old_byte.
module blt_nib_merge
  import blt_pkg::*;
(
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       en_upper,
  input  logic       en_lower,
  output logic [7:0] merged_c
);

  logic [7:0] mask_c;

  always_comb begin
    mask_c   = (en_upper ? NIB_UPPER_MASK : 8'h00) | (en_lower ? NIB_LOWER_MASK : 8'h00);
    merged_c = (new_byte & mask_c) | (old_byte & ~mask_c);
  end

endmodule

// File: rtl/blt_mem_responder.sv
// SC1 blitter bus responder: CPU halt handshake plus RAM read/write servicing.
// Define BLT_RMW_EN to merge partial writes by read-modify-write instead of nibble enables.
module blt_mem_responder
  import blt_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              halt,
  output logic              halt_ack,
  output logic              cpu_halt,
  input  logic              cpu_ba,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] blt_address,
  input  logic [DATA_W-1:0] blt_wdata,
  input  logic              en_upper,
  input  logic              en_lower,
  output logic [DATA_W-1:0] blt_rdata,
  output logic              blt_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_nib_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  blt_state_e        state, state_d;
  logic              cpu_halt_d, halt_ack_d, blt_ack_d, mem_re_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, blt_rdata_d;
  logic [1:0]        mem_nib_en_d;

`ifdef BLT_RMW_EN
  logic [DATA_W-1:0] merged_c;

  blt_nib_merge u_nib_merge (
    .old_byte (mem_rdata),
    .new_byte (blt_wdata),
    .en_upper (en_upper),
    .en_lower (en_lower),
    .merged_c (merged_c)
  );
`endif

  // Next state, then every registered output derived from the state being entered.
  always_comb begin
    state_d      = state;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    blt_rdata_d  = blt_rdata;
    mem_nib_en_d = 2'b00;

    case (state)
      IDLE:    if (halt) state_d = WAIT_BA;
      WAIT_BA: begin
        if (!halt)       state_d = IDLE;
        else if (cpu_ba) state_d = GRANT;
      end
      GRANT: begin
        if (!halt)      state_d = IDLE;
        else if (read)  state_d = RD;
        else if (write) begin
`ifdef BLT_RMW_EN
          if (en_upper && en_lower)      state_d = WR;
          else if (en_upper || en_lower) state_d = RMW_RD;
          else                           state_d = ACK;
`else
          if (en_upper || en_lower) state_d = WR;
          else                      state_d = ACK;
`endif
        end
      end
      // An aborted halt still lets the RAM strobe finish, but suppresses the ack.
      RD, WR:  if (mem_ready) state_d = halt ? ACK : IDLE;
`ifdef BLT_RMW_EN
      RMW_RD:  if (mem_ready) state_d = halt ? RMW_WR : IDLE;
      RMW_WR:  if (mem_ready) state_d = halt ? ACK : IDLE;
`endif
      ACK:     state_d = GRANT;
      default: state_d = IDLE;
    endcase

    cpu_halt_d = (state_d != IDLE);
    halt_ack_d = (state_d != IDLE) && (state_d != WAIT_BA);
    blt_ack_d  = (state_d == ACK);
    mem_re_d   = (state_d == RD) || (state_d == RMW_RD);
    mem_we_d   = (state_d == WR) || (state_d == RMW_WR);

    if (state == GRANT && (mem_re_d || mem_we_d)) mem_addr_d = blt_address;
    if (state == GRANT && state_d == WR)          mem_wdata_d = blt_wdata;
    if (state == RD && mem_ready)                 blt_rdata_d = mem_rdata;

`ifdef BLT_RMW_EN
    if (state == RMW_RD && state_d == RMW_WR) mem_wdata_d = merged_c;
    if (mem_re_d || mem_we_d)                 mem_nib_en_d = NIB_EN_ALL;
`else
    if (mem_we_d)      mem_nib_en_d = {en_upper, en_lower};
    else if (mem_re_d) mem_nib_en_d = NIB_EN_ALL;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cpu_halt   <= 1'b0;
      halt_ack   <= 1'b0;
      blt_ack    <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      blt_rdata  <= '0;
      mem_nib_en <= 2'b00;
    end else begin
      state      <= state_d;
      cpu_halt   <= cpu_halt_d;
      halt_ack   <= halt_ack_d;
      blt_ack    <= blt_ack_d;
      mem_re     <= mem_re_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      blt_rdata  <= blt_rdata_d;
      mem_nib_en <= mem_nib_en_d;
    end
  end

endmodule
